bsg_sha256_disassembler: RTL and testbench
==========================================

Name: bsg_sha256_disassembler

Overview:
- Output-side serializer for the SHA-256 datapath; the counterpart of the assembler.
- Accepts one 256-bit digest from the core over a valid/ready handshake.
- Emits the digest as a sequence of ring packets over a valid/yumi handshake.
- Each packet carries id_p, a word index and a 64-bit payload slice, so the ring-side receiver can reassemble the digest.

Parameters:
- ring_width_p, 80: ring packet width; payload width = ring_width_p-16.
- digest_width_p, 256: digest width; must be an exact multiple of the payload width.
- id_p, 0: 8-bit node id placed in every packet header.

Ports:
- clk_i  in  1  clock
- reset_i  in  1  synchronous active-high reset
- v_i  in  1  digest valid from core
- data_i  in  digest_width_p  digest from core
- ready_o  out  1  block can accept a digest this cycle
- v_o  out  1  ring packet valid
- data_o  out  ring_width_p  ring packet
- yumi_i  in  1  consumer takes data_o this cycle; legal only when v_o=1

Behaviour:
- Clocking and reset:
  - One clock, clk_i. reset_i is synchronous, active-high, sampled on the clk_i rising edge.
  - While reset_i=1: ready_o=0, v_o=0, data_o=0.
  - After reset, state=IDLE, count=0, shift register=0.
  - First cycle with reset_i=0: ready_o=1.
- Derived constants:
  - W = payload width = ring_width_p-16 (64 by default).
  - N = digest_width_p/W (4 by default).
  - idx width = clog2(N) (2 bits by default).
- Packet format, data_o when v_o=1:
  - [ring_width_p-1 -: 8] = id_p
  - next bit = last flag (1 on word N-1)
  - following bits = zero, down to bit W+idx width
  - [W+idx width-1 : W] = word index
  - [W-1:0] = payload
  - data_o=0 whenever v_o=0.
- Word order: most-significant first. Word k = data_i[digest_width_p-1-k*W -: W].
- IDLE state:
  - ready_o=1, v_o=0.
  - On v_i & ready_o: capture data_i into the shift register, set count=0, go to SEND.
  - v_i with ready_o=0 is ignored. The core must hold v_i until accepted.
- SEND state:
  - ready_o=0, v_o=1.
  - data_o shows word[count], stable until yumi_i.
  - On yumi_i with count<N-1: count+1, shift register advances one word.
  - On yumi_i with count=N-1: go to IDLE, count=0.
  - No yumi_i: hold everything.
- Latency and throughput:
  - First v_o is one cycle after the accepting edge.
  - ready_o returns the cycle after the last yumi_i.
  - ready_o never depends combinationally on yumi_i.
  - Minimum N+1 cycles per digest (5 by default).
- Boundary conditions:
  - yumi_i while v_o=0: ignored, no state change.
  - v_i during SEND: ignored, not buffered.
  - reset_i during SEND: remaining words are discarded. The next cycle is the reset state above, with no partial packet.
  - v_i and reset_i in the same cycle: reset wins, digest is not captured.
- Assertions (simulation only):
  - yumi_i implies v_o.
  - digest_width_p % W == 0.

Test Plan:
- Reset check: hold reset_i for 3 cycles, then release.
  - During reset: ready_o=0, v_o=0, data_o=0.
  - First cycle after release: ready_o=1.
- Single digest, id_p=8'h2A: send SHA-256("abc") = ba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad with v_i for 1 cycle; yumi_i held high.
  - v_o is high for exactly 4 consecutive cycles.
  - Payloads in order: ba7816bf8f01cfea, 414140de5dae2223, b00361a396177a9c, b410ff61f20015ad.
  - Indices 0..3; last flag=1 only on index 3; data_o[79:72]=8'h2A.
  - ready_o=1 on the following cycle.
- Backpressure: same digest, yumi_i pulsed every third cycle.
  - data_o is stable between yumis; no word is skipped or duplicated.
  - ready_o stays 0 until the cycle after the 4th yumi.
- Illegal/ignored inputs:
  - Drive yumi_i=1 in IDLE: no v_o, state unchanged.
  - Drive v_i with digest 0xFF..FF during SEND: the in-flight digest completes unchanged and the second digest is not emitted.
- Reset mid-stream: reset_i after the 2nd yumi.
  - Next cycle: v_o=0, ready_o=0.
  - A new digest 0x00..01 afterwards produces payloads 0, 0, 0, 1 with indices starting at 0.
- Back-to-back: two digests, v_i held continuously, yumi_i always high.
  - Second digest accepted on the cycle ready_o rises.
  - 8 packets total, one idle gap between the two packet groups, 10-cycle total from first accept.

Source files
------------

// File: rtl/bsg_sha256_disassembler.sv
// Serializes one digest into N ring packets (id, last flag, word index, payload), MS word first.
// First packet one cycle after accept; data_o holds until yumi_i, ready_o returns the cycle after the last yumi.
module bsg_sha256_disassembler #(
  parameter int          ring_width_p   = 80,
  parameter int          digest_width_p = 256,
  parameter logic [7:0]  id_p           = 8'h00
) (
  input  logic                      clk_i,
  input  logic                      reset_i,
  input  logic                      v_i,
  input  logic [digest_width_p-1:0] data_i,
  output logic                      ready_o,
  output logic                      v_o,
  output logic [ring_width_p-1:0]   data_o,
  input  logic                      yumi_i
);

  localparam int W     = ring_width_p - 16;
  localparam int N     = digest_width_p / W;
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

  typedef enum logic {S_IDLE, S_SEND} state_e;

  state_e                    r_state, w_state_nxt;
  logic [IDX_W-1:0]          r_count, w_count_nxt;
  logic [digest_width_p-1:0] r_shift, w_shift_nxt;
  logic                      w_last;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_state <= S_IDLE;
      r_count <= '0;
      r_shift <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_count <= w_count_nxt;
      r_shift <= w_shift_nxt;
    end
  end

  // Outputs are gated by reset_i so the block is quiet from the very first reset cycle.
  always_comb begin
    w_state_nxt = r_state;
    w_count_nxt = r_count;
    w_shift_nxt = r_shift;
    w_last      = (r_count == LAST_IDX);
    ready_o     = 1'b0;
    v_o         = 1'b0;
    data_o      = '0;
    if (!reset_i) begin
      case (r_state)
        S_IDLE: begin
          ready_o = 1'b1;
          if (v_i) begin
            w_shift_nxt = data_i;
            w_count_nxt = '0;
            w_state_nxt = S_SEND;
          end
        end
        S_SEND: begin
          v_o                           = 1'b1;
          data_o[ring_width_p-1 -: 8]   = id_p;
          data_o[ring_width_p-9]        = w_last;
          data_o[W +: IDX_W]            = r_count;
          data_o[W-1:0]                 = r_shift[digest_width_p-1 -: W];
          if (yumi_i) begin
            if (w_last) begin
              w_count_nxt = '0;
              w_state_nxt = S_IDLE;
            end else begin
              w_count_nxt = r_count + 1'b1;
              w_shift_nxt = r_shift << W;
            end
          end
        end
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

`ifndef SYNTHESIS
  always_ff @(posedge clk_i) begin
    assert (digest_width_p % W == 0)
      else $error("digest_width_p must be a multiple of ring_width_p-16");
    if (!reset_i) begin
      assert (!yumi_i || v_o)
        else $warning("yumi_i seen while v_o low; ignored");
    end
  end
`endif

endmodule

// File: tb/tb_bsg_sha256_disassembler.sv
// Directed + random stimulus for the digest disassembler, checked against a packet-queue model.
module tb_bsg_sha256_disassembler;
  localparam int RW = 80;
  localparam int DW = 256;
  localparam int W  = 64;
  localparam int N  = 4;
  localparam logic [7:0] ID = 8'h2A;
  localparam logic [DW-1:0] ABC =
    256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;

  logic          clk = 1'b0;
  logic          reset_i, v_i, yumi_i, ready_o, v_o;
  logic [DW-1:0] data_i;
  logic [RW-1:0] data_o;

  int            checks = 0;
  int            errors = 0;
  logic [RW-1:0] exp_q[$];
  int            n_acc  = 0;
  logic          obs_v;

  always #5 clk = ~clk;

  bsg_sha256_disassembler #(
    .ring_width_p  (RW),
    .digest_width_p(DW),
    .id_p          (ID)
  ) dut (
    .clk_i  (clk),
    .reset_i(reset_i),
    .v_i    (v_i),
    .data_i (data_i),
    .ready_o(ready_o),
    .v_o    (v_o),
    .data_o (data_o),
    .yumi_i (yumi_i)
  );

  function automatic logic [RW-1:0] mk_pkt(input logic [DW-1:0] d, input int k);
    logic [DW-1:0] t;
    logic [RW-1:0] p;
    t        = d >> (W * (N - 1 - k));
    p        = '0;
    p[79:72] = ID;
    p[71]    = (k == N - 1);
    p[65:64] = k[1:0];
    p[63:0]  = t[63:0];
    return p;
  endfunction

  // One cycle: drive inputs, check outputs against the model, then advance the model.
  task automatic step(input logic r, input logic v, input logic [DW-1:0] d, input logic y);
    logic          e_rdy, e_v;
    logic [RW-1:0] e_d;
    @(negedge clk);
    reset_i = r;
    v_i     = v;
    data_i  = d;
    yumi_i  = y;
    #1;
    e_rdy = !r && (exp_q.size() == 0);
    e_v   = !r && (exp_q.size() != 0);
    e_d   = e_v ? exp_q[0] : '0;
    obs_v = v_o;
    checks++;
    assert (ready_o === e_rdy) else begin
      errors++; $error("FAIL ready obs=%b exp=%b", ready_o, e_rdy);
    end
    checks++;
    assert (v_o === e_v) else begin
      errors++; $error("FAIL v_o obs=%b exp=%b", v_o, e_v);
    end
    checks++;
    assert (data_o === e_d) else begin
      errors++; $error("FAIL data_o obs=%h exp=%h", data_o, e_d);
    end
    if (r) begin
      exp_q.delete();
    end else if (exp_q.size() == 0) begin
      if (v) begin
        for (int k = 0; k < N; k++) exp_q.push_back(mk_pkt(d, k));
        n_acc++;
      end
    end else if (y) begin
      void'(exp_q.pop_front());
    end
  endtask

  task automatic drain(input int budget);
    for (int i = 0; i < budget; i++) step(1'b0, 1'b0, '0, exp_q.size() != 0);
    checks++;
    assert (exp_q.size() == 0) else begin
      errors++; $error("FAIL drain_budget obs=%0d exp=0", exp_q.size());
    end
  endtask

  initial begin
    int            cnt;
    int            base;
    logic [9:0]    pat;
    logic [DW-1:0] da, db, rnd;

    reset_i = 1'b1; v_i = 1'b0; yumi_i = 1'b0; data_i = '0;

    // Reset for 3 cycles, then idle with ready_o=1.
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, '0, 1'b0);
    step(1'b0, 1'b0, '0, 1'b0);

    // Single digest, yumi_i held high: exactly 4 valid cycles.
    step(1'b0, 1'b1, ABC, 1'b0);
    cnt = 0;
    for (int i = 0; i < 6; i++) begin
      step(1'b0, 1'b0, '0, exp_q.size() != 0);
      cnt += int'(obs_v);
    end
    checks++;
    assert (cnt == 4) else begin
      errors++; $error("FAIL abc_vcount obs=%0d exp=4", cnt);
    end

    // Backpressure: yumi every third cycle.
    step(1'b0, 1'b1, ABC, 1'b0);
    for (int i = 0; i < 16; i++) step(1'b0, 1'b0, '0, (i % 3 == 2) && (exp_q.size() != 0));
    drain(4);

    // yumi_i while idle is ignored.
    step(1'b0, 1'b0, '0, 1'b1);
    step(1'b0, 1'b0, '0, 1'b1);
    step(1'b0, 1'b0, '0, 1'b0);

    // v_i during SEND is ignored and not buffered.
    step(1'b0, 1'b1, ABC, 1'b0);
    step(1'b0, 1'b1, '1, 1'b0);
    step(1'b0, 1'b1, '1, 1'b1);
    drain(6);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, '0, 1'b0);

    // Reset after the 2nd yumi discards the rest.
    step(1'b0, 1'b1, ABC, 1'b0);
    step(1'b0, 1'b0, '0, 1'b1);
    step(1'b0, 1'b0, '0, 1'b1);
    step(1'b1, 1'b1, '1, 1'b0);
    step(1'b0, 1'b0, '0, 1'b0);
    step(1'b0, 1'b1, 256'h1, 1'b0);
    drain(6);

    // Back-to-back with v_i held and yumi_i always high.
    da   = {8{$urandom()}};
    db   = {8{$urandom()}};
    base = n_acc;
    step(1'b0, 1'b1, da, 1'b0);
    pat = '0;
    for (int c = 1; c <= 10; c++) begin
      step(1'b0, (n_acc - base) < 2, db, exp_q.size() != 0);
      pat = {pat[8:0], obs_v};
    end
    checks++;
    assert (pat === 10'b1111011110) else begin
      errors++; $error("FAIL b2b_pattern obs=%b exp=%b", pat, 10'b1111011110);
    end
    checks++;
    assert ((n_acc - base) == 2) else begin
      errors++; $error("FAIL b2b_accepts obs=%0d exp=2", n_acc - base);
    end

    // Random traffic with occasional reset.
    for (int i = 0; i < 400; i++) begin
      rnd = {8{$urandom()}};
      step($urandom_range(0, 40) == 0, 1'($urandom_range(0, 1)), rnd,
           (exp_q.size() != 0) && ($urandom_range(0, 2) != 0));
    end
    drain(12);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
